spi_tx_sequencer: RTL and testbench
===================================

SPI_TX_SEQUENCER -- requirements
Module: spi_tx_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, FIFO depth in bytes; power of two, 2..16.
REQ-002 Parameter GAP_CYCLES, default 2, idle clocks forced between consecutive transfers; 0..255.
REQ-003 Parameter TIMEOUT, default 1023, max clocks to wait for spi_tx_done; 1..65535.
REQ-004 clk  input  1  single system clock, rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 wr_en  input  1  host byte-write strobe, one byte per cycle.
REQ-007 wr_data  input  8  host byte.
REQ-008 full  output  1  FIFO holds DEPTH bytes.
REQ-009 empty  output  1  FIFO holds 0 bytes.
REQ-010 level  output  $clog2(DEPTH)+1  current byte count.
REQ-011 spi_tx_data  output  8  byte presented to SPI core parallel input.
REQ-012 spi_tx_start  output  1  one-cycle transfer-start pulse to SPI core.
REQ-013 spi_tx_done  input  1  SPI core transfer-complete pulse.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 timeout_err  output  1  sticky; set on transfer timeout.
REQ-016 err_clr  input  1  clears timeout_err and overflow.
REQ-017 overflow  output  1  sticky write-while-full flag (see Configuration).

Function
REQ-018 Write accepted at a rising edge when wr_en=1 and full=0; when full=1 the byte is dropped and FIFO contents are unchanged.
REQ-019 A same-cycle push and pop when full=1 still drops the push; with 0<level<DEPTH, level is unchanged.
REQ-020 Pointers wrap modulo DEPTH; level = write count minus pop count, never exceeding DEPTH and never below 0.
REQ-021 FSM states: IDLE, LOAD, WAIT_DONE, GAP.
REQ-022 IDLE -> LOAD when empty=0; otherwise remain in IDLE.
REQ-023 On the IDLE->LOAD edge, the head byte is registered into spi_tx_data and popped.
REQ-024 In LOAD (exactly one cycle), spi_tx_start=1; the next state is WAIT_DONE.
REQ-025 spi_tx_data is held stable from LOAD until the next LOAD.
REQ-026 WAIT_DONE: when spi_tx_done=1, go to GAP.
REQ-027 WAIT_DONE: when TIMEOUT clocks elapse without spi_tx_done, set timeout_err and go to GAP.
REQ-028 spi_tx_done outside WAIT_DONE is ignored.
REQ-029 GAP: remain GAP_CYCLES clocks, then go to IDLE; with GAP_CYCLES=0, GAP lasts one cycle.
REQ-030 Latency: a byte written into an empty FIFO while in IDLE produces spi_tx_start in the 2nd cycle after the accepting edge.
REQ-031 If err_clr and a flag-set event occur in the same cycle, the set wins.

Reset
REQ-032 While rst_n=0, regardless of clk:
- FSM=IDLE; FIFO pointers and level=0.
- empty=1, full=0, spi_tx_start=0, spi_tx_data=8'h00, busy=0, timeout_err=0, overflow=0.
REQ-033 Reset mid-transfer discards all queued bytes; no spi_tx_start is issued until a new write after rst_n rises.

Configuration
REQ-034 Macro SPI_TXSEQ_OVF_EN defined: overflow sets when wr_en=1 and full=1 and holds until err_clr or reset.
REQ-035 SPI_TXSEQ_OVF_EN undefined: overflow is constant 0 and no flag register exists; drop behaviour is unchanged.

Verification
REQ-036 Reset, then write 8'hA5 -> spi_tx_start high 2 cycles later with spi_tx_data=8'hA5, busy=1, empty=1.
REQ-037 Write 8'h01..8'h04 back-to-back (DEPTH=4), done pulse 5 cycles after each start -> starts issued in order 01,02,03,04, each ≥GAP_CYCLES+1 cycles after the previous done.
REQ-038 While in WAIT_DONE, fill to full and write 8'hFF -> byte dropped, level=4, overflow=1 with macro and 0 without; err_clr -> overflow=0.
REQ-039 TIMEOUT=16, no spi_tx_done -> timeout_err=1 after 16 WAIT_DONE cycles, then GAP, then the next byte starts.
REQ-040 rst_n low for 1 cycle during WAIT_DONE with 3 bytes queued -> level=0, FSM=IDLE, no further spi_tx_start.

Source files
------------

// File: rtl/spi_tx_sequencer.sv
// Byte FIFO feeding an SPI core: one start pulse per byte, done/timeout wait, inter-transfer gap.
// Optional sticky write-while-full flag enabled by defining SPI_TXSEQ_OVF_EN.
module spi_tx_sequencer #(
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned GAP_CYCLES = 2,
   parameter int unsigned TIMEOUT    = 1023
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     wr_en,
   input  logic [7:0]               wr_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level,
   output logic [7:0]               spi_tx_data,
   output logic                     spi_tx_start,
   input  logic                     spi_tx_done,
   output logic                     busy,
   output logic                     timeout_err,
   input  logic                     err_clr,
   output logic                     overflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;
   localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
   localparam logic [15:0] GAP_LAST = 16'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, LOAD, WAIT_DONE, GAP} state_t;

   state_t        state, state_nxt;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [15:0]   cnt;
   logic          push, pop, to_hit;

   assign full   = (level == LW'(DEPTH));
   assign empty  = (level == '0);
   assign push   = wr_en && !full;
   assign pop    = (state == IDLE) && !empty;
   assign to_hit = (state == WAIT_DONE) && !spi_tx_done && (cnt == TO_LAST);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data;
   end

   // Push is gated by full, so a push+pop while full still drops the push.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) spi_tx_data <= '0;
      else if (pop) spi_tx_data <= mem[rd_ptr];
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Shared timer: restarts on every state change, counts in WAIT_DONE and GAP
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                 cnt <= '0;
      else if (state_nxt != state)                cnt <= '0;
      else if (state == WAIT_DONE || state == GAP) cnt <= cnt + 1'b1;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:      if (!empty) state_nxt = LOAD;
         LOAD:      state_nxt = WAIT_DONE;
         WAIT_DONE: if (spi_tx_done || cnt == TO_LAST) state_nxt = GAP;
         GAP:       if (cnt == GAP_LAST) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      spi_tx_start = (state == LOAD);
      busy         = (state != IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       timeout_err <= 1'b0;
      else if (to_hit)  timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
   end

`ifdef SPI_TXSEQ_OVF_EN
   logic ovf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              ovf_q <= 1'b0;
      else if (wr_en && full)  ovf_q <= 1'b1;
      else if (err_clr)        ovf_q <= 1'b0;
   end

   assign overflow = ovf_q;
`else
   assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_spi_tx_sequencer.sv
// Directed self-checking bench for spi_tx_sequencer (DEPTH=4, GAP_CYCLES=2, TIMEOUT=16).
module tb_spi_tx_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = '0;
   logic       full, empty;
   logic [2:0] level;
   logic [7:0] spi_tx_data;
   logic       spi_tx_start;
   logic       spi_tx_done = 1'b0;
   logic       busy, timeout_err;
   logic       err_clr = 1'b0;
   logic       overflow;

`ifdef SPI_TXSEQ_OVF_EN
   localparam logic OVF_EXP = 1'b1;
`else
   localparam logic OVF_EXP = 1'b0;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int done_cyc = 0;
   int taken = 0;
   logic [7:0] start_q[$];
   int         start_cyc[$];

   spi_tx_sequencer #(.DEPTH(4), .GAP_CYCLES(2), .TIMEOUT(16)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
      .full(full), .empty(empty), .level(level),
      .spi_tx_data(spi_tx_data), .spi_tx_start(spi_tx_start), .spi_tx_done(spi_tx_done),
      .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr), .overflow(overflow)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Log every start pulse with the byte presented and the cycle it appeared in
   always @(negedge clk) begin
      if (spi_tx_start) begin
         start_q.push_back(spi_tx_data);
         start_cyc.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_bytes(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3, input int n);
      logic [7:0] bytes [4];
      bytes = '{b0, b1, b2, b3};
      for (int i = 0; i < n; i++) begin
         wr_en = 1'b1;
         wr_data = bytes[i];
         tick();
      end
      wr_en = 1'b0;
   endtask

   task automatic serve(input logic [7:0] exp, input bit chk_gap);
      int n = 0;
      int s;
      while (start_q.size() <= taken && n < 60) begin
         tick();
         n++;
      end
      if (start_q.size() <= taken) begin
         check("start_wait", 32'd0, 32'd1);
         return;
      end
      check("tx_data", 32'(start_q[taken]), 32'(exp));
      if (chk_gap) check("gap_dist", 32'(start_cyc[taken] - done_cyc), 32'd3);
      s = start_cyc[taken];
      taken++;
      while (cyc < s + 4) tick();
      spi_tx_done = 1'b1;
      tick();
      spi_tx_done = 1'b0;
      done_cyc = cyc;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 40) begin
         tick();
         n++;
      end
      check("idle_wait", 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int s, base;

      // Reset values while rst_n is low, before any clock edge
      #2;
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_level", 32'(level), 32'd0);
      check("rst_start", 32'(spi_tx_start), 32'd0);
      check("rst_data", 32'(spi_tx_data), 32'h00);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_tmo", 32'(timeout_err), 32'd0);
      check("rst_ovf", 32'(overflow), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Single byte: start in the second cycle after the accepting edge
      wr_en = 1'b1;
      wr_data = 8'hA5;
      tick();
      wr_en = 1'b0;
      check("a5_level", 32'(level), 32'd1);
      check("a5_start_early", 32'(spi_tx_start), 32'd0);
      tick();
      check("a5_start", 32'(spi_tx_start), 32'd1);
      check("a5_data", 32'(spi_tx_data), 32'hA5);
      check("a5_busy", 32'(busy), 32'd1);
      check("a5_empty", 32'(empty), 32'd1);
      tick();
      check("a5_start_1cyc", 32'(spi_tx_start), 32'd0);
      serve(8'hA5, 1'b0);
      wait_idle();

      // Four back-to-back bytes, in order, with the forced gap
      write_bytes(8'h01, 8'h02, 8'h03, 8'h04, 4);
      check("q4_level", 32'(level), 32'd3);
      serve(8'h01, 1'b0);
      serve(8'h02, 1'b1);
      serve(8'h03, 1'b1);
      serve(8'h04, 1'b1);
      wait_idle();

      // Fill while in WAIT_DONE, then write while full
      write_bytes(8'h11, 8'h22, 8'h33, 8'h44, 4);
      wr_en = 1'b1;
      wr_data = 8'h55;
      tick();
      check("fill_full", 32'(full), 32'd1);
      check("fill_busy", 32'(busy), 32'd1);
      wr_data = 8'hFF;
      tick();
      wr_en = 1'b0;
      check("ovf_level", 32'(level), 32'd4);
      check("ovf_flag", 32'(overflow), 32'(OVF_EXP));
      wr_en = 1'b1;
      err_clr = 1'b1;
      tick();
      wr_en = 1'b0;
      check("ovf_set_wins", 32'(overflow), 32'(OVF_EXP));
      check("ovf_level2", 32'(level), 32'd4);
      tick();
      err_clr = 1'b0;
      check("ovf_clr", 32'(overflow), 32'd0);
      serve(8'h11, 1'b0);
      serve(8'h22, 1'b1);
      serve(8'h33, 1'b1);
      serve(8'h44, 1'b1);
      serve(8'h55, 1'b1);
      wait_idle();
      repeat (5) tick();
      check("no_dropped_start", 32'(start_q.size()), 32'(taken));

      // Timeout after 16 WAIT_DONE cycles, then gap, then next byte
      write_bytes(8'h77, 8'h88, 8'h00, 8'h00, 2);
      begin
         int n = 0;
         while (start_q.size() <= taken && n < 60) begin
            tick();
            n++;
         end
      end
      if (start_q.size() <= taken) begin
         check("tmo_start_wait", 32'd0, 32'd1);
      end else begin
         check("tmo_data", 32'(start_q[taken]), 32'h77);
         s = start_cyc[taken];
         taken++;
         while (cyc < s + 16) tick();
         check("tmo_not_yet", 32'(timeout_err), 32'd0);
         check("tmo_busy", 32'(busy), 32'd1);
         tick();
         check("tmo_set", 32'(timeout_err), 32'd1);
         done_cyc = cyc;
         serve(8'h88, 1'b1);
         wait_idle();
         check("tmo_sticky", 32'(timeout_err), 32'd1);
         err_clr = 1'b1;
         tick();
         err_clr = 1'b0;
         check("tmo_clr", 32'(timeout_err), 32'd0);
      end

      // Reset during WAIT_DONE with three bytes queued
      write_bytes(8'hA1, 8'hA2, 8'hA3, 8'hA4, 4);
      check("mid_level", 32'(level), 32'd3);
      check("mid_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_level", 32'(level), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_empty", 32'(empty), 32'd1);
      check("mid_rst_data", 32'(spi_tx_data), 32'h00);
      tick();
      rst_n = 1'b1;
      base = start_q.size();
      tick();
      spi_tx_done = 1'b1;
      tick();
      spi_tx_done = 1'b0;
      check("done_ignored_busy", 32'(busy), 32'd0);
      check("done_ignored_tmo", 32'(timeout_err), 32'd0);
      repeat (20) tick();
      check("post_rst_starts", 32'(start_q.size()), 32'(base));
      check("post_rst_level", 32'(level), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
